dmem_lsu: RTL and testbench

Load/store unit between the hart's execute/memory stage and a realistic, multi-cycle data memory. It accepts one byte-addressed load or store per request and checks alignment. It converts the request into a word-aligned, byte-masked memory transaction, waits on the memory handshake, and returns sign- or zero-extended load data or a trap/error status. It replaces the combinational dmem port once memory gains latency.

---
 rtl/lsu_pkg.sv | 64 ++++++
 rtl/dmem_lane_align.sv | 22 ++
 rtl/dmem_lsu.sv | 157 +++++++++++++++
 tb/tb_dmem_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store path: access size
// encodings, LSU state encoding, and the byte-lane/extension helpers that the
// single-cycle hart datapath reuses as well.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Illegal size, or an address not naturally aligned to the access size.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    case (size)
      SZ_B:    f = 1'b0;
      SZ_H:    f = off[0];
      SZ_W:    f = (off != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Move the addressed lane(s) to bit 0, then sign- or zero-extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [1:0] size, input logic is_unsigned);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    lane = rdata >> {off, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (size)
      SZ_B: begin
        r = b;
        return is_unsigned ? {24'd0, lane[7:0]} : r;
      end
      SZ_H: begin
        r = h;
        return is_unsigned ? {16'd0, lane[15:0]} : r;
      end
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data and lane enables toward memory,
// extended load data back toward the core, plus the alignment fault flag.
module dmem_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  assign mask      = lane_mask(size, off);
  assign wdata_sh  = wdata << {off, 3'b000};
  assign rdata_ext = load_extend(rdata, off, size, is_unsigned);
  assign fault     = access_fault(size, off);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a multi-cycle data memory. One transaction in
// flight: capture the request, issue a word-aligned byte-masked access, wait
// for completion (bounded by WAIT_TIMEOUT), then pulse a response.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap,
  output logic        o_rsp_err,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  lsu_state_e  state;
  logic [7:0]  wait_cnt;

  // Request fields captured at acceptance
  logic [1:0]  off_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic        wen_p0;

  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_fault;

  assign o_req_ready = (state == IDLE);

  // Aligner sees the live request in IDLE and the captured request afterwards
  always_comb begin
    al_off  = off_p0;
    al_size = size_p0;
    al_uns  = uns_p0;
    if (state == IDLE) begin
      al_off  = i_req_addr[1:0];
      al_size = i_req_size;
      al_uns  = i_req_unsigned;
    end
  end

  dmem_lane_align u_align (
    .off         (al_off),
    .size        (al_size),
    .is_unsigned (al_uns),
    .wdata       (i_req_wdata),
    .rdata       (i_mem_rdata),
    .mask        (al_mask),
    .wdata_sh    (al_wdata),
    .rdata_ext   (al_rdata),
    .fault       (al_fault)
  );

  // Transaction FSM with registered memory and response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      off_p0      <= 2'b00;
      size_p0     <= 2'b00;
      uns_p0      <= 1'b0;
      wen_p0      <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_trap  <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_ren   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_wdata <= 32'd0;
      o_mem_mask  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            off_p0  <= i_req_addr[1:0];
            size_p0 <= i_req_size;
            uns_p0  <= i_req_unsigned;
            wen_p0  <= i_req_wen;
            if (al_fault) begin
              // Faulting request never touches memory
              o_rsp_valid <= 1'b1;
              o_rsp_trap  <= 1'b1;
              o_rsp_rdata <= 32'd0;
              state       <= RESP;
            end else begin
              o_mem_valid <= 1'b1;
              o_mem_addr  <= {i_req_addr[31:2], 2'b00};
              o_mem_ren   <= ~i_req_wen;
              o_mem_wen   <= i_req_wen;
              o_mem_wdata <= al_wdata;
              o_mem_mask  <= al_mask;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            wait_cnt    <= 8'd0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= wen_p0 ? 32'd0 : al_rdata;
            state       <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= 32'd0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          o_rsp_valid <= 1'b0;
          o_rsp_trap  <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= 32'd0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: each driven request pushes its expected
// response; a monitor pops and compares whenever the DUT pulses o_rsp_valid.
module tb_dmem_lsu;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_wen = 1'b0;
  logic [31:0] i_req_addr = 32'd0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_wdata = 32'd0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_trap;
  logic        o_rsp_err;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  dmem_lsu #(.WAIT_TIMEOUT(TO)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_wen      (i_req_wen),
    .i_req_addr     (i_req_addr),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_trap     (o_rsp_trap),
    .o_rsp_err      (o_rsp_err),
    .o_mem_valid    (o_mem_valid),
    .i_mem_ready    (i_mem_ready),
    .o_mem_addr     (o_mem_addr),
    .o_mem_ren      (o_mem_ren),
    .o_mem_wen      (o_mem_wen),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_mask     (o_mem_mask),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        trap;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ready"}, 32'(o_req_ready), 32'd1);
    chk({name, "_ctl"}, 32'({o_rsp_valid, o_rsp_trap, o_rsp_err, o_mem_valid,
                             o_mem_ren, o_mem_wen, o_mem_mask}), 32'd0);
    chk({name, "_rdata"}, o_rsp_rdata, 32'd0);
    chk({name, "_maddr"}, o_mem_addr, 32'd0);
    chk({name, "_mwdata"}, o_mem_wdata, 32'd0);
  endtask

  // Response monitor
  always @(negedge i_clk) begin
    if (i_rst_n && o_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdata"}, o_rsp_rdata, e.rdata);
        chk({e.name, "_trap"}, 32'(o_rsp_trap), 32'(e.trap));
        chk({e.name, "_err"}, 32'(o_rsp_err), 32'(e.err));
        chk({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic run_txn(input string name, input logic wen, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] mrdata, input int rdy_dly, input int rv_dly,
                         input logic rv_en, input logic dup_req, input logic abort);
    logic [1:0]  off;
    logic        fault;
    logic [31:0] v, exp_rd, exp_wd;
    logic [3:0]  exp_mask;
    int          nb, acc_cyc;
    logic        acc;
    exp_t        e;

    off   = addr[1:0];
    fault = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && off != 2'd0);
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_mask = 4'd0;
    for (int j = 0; j < 4; j++)
      if (j >= int'(off) && j < int'(off) + nb) exp_mask[j] = 1'b1;
    exp_wd = wdata << (8 * off);
    v      = mrdata >> (8 * off);
    case (size)
      2'd0:    exp_rd = uns ? (v & 32'h0000_00FF) : {{24{v[7]}}, v[7:0]};
      2'd1:    exp_rd = uns ? (v & 32'h0000_FFFF) : {{16{v[15]}}, v[15:0]};
      default: exp_rd = v;
    endcase
    if (wen) exp_rd = 32'd0;

    @(posedge i_clk); #1;
    i_req_valid    = 1'b1;
    i_req_wen      = wen;
    i_req_addr     = addr;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_wdata    = wdata;

    acc = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_req_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!acc) begin
      chk({name, "_accept"}, 32'd0, 32'd1);
      i_req_valid = 1'b0;
      return;
    end

    e.name = name;
    if (fault) begin
      e.rdata = 32'd0; e.trap = 1'b1; e.err = 1'b0; e.cyc = acc_cyc + 1;
    end else if (!rv_en) begin
      e.rdata = 32'd0; e.trap = 1'b0; e.err = 1'b1; e.cyc = acc_cyc + 2 + rdy_dly + TO;
    end else begin
      e.rdata = exp_rd; e.trap = 1'b0; e.err = 1'b0; e.cyc = acc_cyc + 3 + rdy_dly + rv_dly;
    end
    sb.push_back(e);

    @(posedge i_clk); #1;
    i_req_valid = dup_req;
    if (dup_req) begin
      i_req_addr  = addr + 32'h100;
      i_req_wen   = ~wen;
      i_req_wdata = ~wdata;
    end

    if (fault) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge i_clk);
        chk({name, "_nomem"}, 32'(o_mem_valid), 32'd0);
      end
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        i_mem_ready = (i == rdy_dly);
        @(negedge i_clk);
        chk({name, "_mvalid"}, 32'(o_mem_valid), 32'd1);
        chk({name, "_maddr"}, o_mem_addr, {addr[31:2], 2'b00});
        chk({name, "_mmask"}, 32'(o_mem_mask), 32'(exp_mask));
        chk({name, "_mwdata"}, o_mem_wdata, exp_wd);
        chk({name, "_mrw"}, 32'({o_mem_ren, o_mem_wen}), 32'({~wen, wen}));
        chk({name, "_busy"}, 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
      end
      i_mem_ready = 1'b0;
      i_req_valid = 1'b0;
      if (abort) begin
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_reset({name, "_rst"});
        sb.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        return;
      end
      if (rv_en) begin
        repeat (rv_dly) begin
          @(posedge i_clk); #1;
        end
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = mrdata;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = $urandom;
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge i_clk);
    if (sb.size() != 0) begin
      chk({name, "_rsp"}, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check_reset("por");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    //           name     wen   addr           sz    uns   wdata          mrdata        rdy rv rv_en dup  abort
    run_txn("sb",      1'b1, 32'h0000_2003, 2'd0, 1'b0, 32'h0000_00AB, 32'h0,        0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("lh",      1'b0, 32'h0000_1002, 2'd1, 1'b0, 32'h0,        32'h8001_1234, 0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("lhu",     1'b0, 32'h0000_1002, 2'd1, 1'b1, 32'h0,        32'h8001_1234, 0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("lb",      1'b0, 32'h0000_1001, 2'd0, 1'b0, 32'h0,        32'h1234_9A78, 0, 1, 1'b1, 1'b0, 1'b0);
    run_txn("lbu",     1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0,        32'hF234_9A78, 1, 0, 1'b1, 1'b0, 1'b0);
    run_txn("sw",      1'b1, 32'h0000_3000, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h5555_5555, 0, 2, 1'b1, 1'b0, 1'b0);
    run_txn("sh",      1'b1, 32'h0000_3002, 2'd1, 1'b0, 32'hFFFF_1234, 32'h0,        0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("lw_mis",  1'b0, 32'h0000_1001, 2'd2, 1'b0, 32'h0,        32'h0,        0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("lh_mis",  1'b0, 32'h0000_1003, 2'd1, 1'b0, 32'h0,        32'h0,        0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("sz_ill",  1'b0, 32'h0000_1000, 2'd3, 1'b0, 32'h0,        32'h0,        0, 0, 1'b1, 1'b0, 1'b0);
    run_txn("bp",      1'b0, 32'h0000_4000, 2'd2, 1'b0, 32'h0,        32'hCAFE_F00D, 5, 1, 1'b1, 1'b1, 1'b0);
    run_txn("tmo",     1'b0, 32'h0000_5000, 2'd2, 1'b0, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 1'b0);

    // Late completion after the timeout must not produce a response
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h1111_2222;
    @(negedge i_clk);
    chk("late_idle", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("late_norsp", 32'(o_rsp_valid), 32'd0);
    end

    run_txn("abrt",    1'b0, 32'h0000_6004, 2'd2, 1'b0, 32'h0,        32'h0,        0, 0, 1'b1, 1'b0, 1'b1);
    run_txn("post",    1'b0, 32'h0000_6004, 2'd2, 1'b0, 32'h0,        32'h0BAD_C0DE, 0, 0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_txn("rnd", 1'($urandom_range(0, 1)), 32'h0000_7000 + 32'($urandom_range(0, 15)),
              2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, 1'b0, 1'b0);
    end

    repeat (3) @(negedge i_clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
